conv_window_streamer: RTL and testbench

- Transmit side of the a_input/a_valid/a_ready stream into the convolution accelerator.
- On start, walks an input feature map held in an external word-addressed memory in convolution-window order:
  - outer loops: output row y, then output column x, both stepped by CONV_STEP;
  - inner loops: kernel row ky, kernel column kx, input channel ch.
- For each element it issues a memory read and pushes the data onto a valid/ready stream.
- Zero padding is generated internally, with no memory access.

---
 rtl/conv_stream_pkg.sv | 10 +
 rtl/stream_fifo2.sv | 33 +++
 rtl/conv_window_streamer.sv | 94 +++++++++
 tb/tb_conv_window_streamer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: signed coordinate type and FSM state encoding shared by the window streamer
package conv_stream_pkg;
  localparam int MAX_FM_DIM = 128;
  localparam int COORD_W = $clog2(MAX_FM_DIM) + 2;
  typedef logic signed [COORD_W-1:0] coord_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_RUN = ST_RUN, S_DRAIN = ST_DRAIN} state_t;
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry FIFO with registered head; clk/rst, i_push+i_data in, i_pop, o_valid+o_data head, o_count occupancy
module stream_fifo2 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_head, r_tail;
  logic [1:0] r_count;
  logic w_pop, w_push;
  assign w_pop = i_pop && r_count != 2'd0;
  assign w_push = i_push && (r_count != 2'd2 || w_pop);
  assign o_valid = r_count != 2'd0;
  assign o_data = r_head;
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_pop && r_count == 2'd2) r_head <= r_tail;
      else if (w_push && (r_count == 2'd0 || w_pop)) r_head <= i_data;
      if (w_push && (r_count == 2'd2 || (r_count == 2'd1 && !w_pop))) r_tail <= i_data;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
endmodule

// File: rtl/conv_window_streamer.sv
// conv_window_streamer: walks a feature map in conv-window order (y,x,ky,kx,ch), reads memory or pads zero, streams via valid/ready with window/done flags
module conv_window_streamer
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FEATURE_MAP_WIDTH = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS = 2,
  parameter int KERNEL_SIZE = 3,
  parameter int CONV_STEP = 1,
  parameter int ADDR_WIDTH = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * INPUT_NB_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  running,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last_window,
  output logic                  out_done
);
  localparam int CH_W = INPUT_NB_CHANNELS > 1 ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam coord_t C_W = coord_t'(FEATURE_MAP_WIDTH);
  localparam coord_t C_H = coord_t'(FEATURE_MAP_HEIGHT);
  localparam coord_t C_K1 = coord_t'(KERNEL_SIZE - 1);
  localparam coord_t C_HALF = coord_t'(KERNEL_SIZE / 2);
  localparam coord_t C_STEP = coord_t'(CONV_STEP);
  localparam logic [CH_W-1:0] C_CLAST = CH_W'(INPUT_NB_CHANNELS - 1);
  state_t r_state, w_state_nxt;
  coord_t r_y, r_x, r_ky, r_kx, w_iy, w_ix;
  logic [CH_W-1:0] r_ch;
  logic r_pend, r_pend_pad, r_pend_last, r_pend_done;
  logic w_gen, w_pad, w_ch_wrap, w_kx_wrap, w_ky_wrap, w_last_x, w_last_y, w_last_win, w_final;
  logic w_hs, w_drained;
  logic [1:0] w_count;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH+1:0] w_fifo_out;
  assign w_iy = r_y + r_ky - C_HALF;
  assign w_ix = r_x + r_kx - C_HALF;
  assign w_pad = w_iy[COORD_W-1] || w_ix[COORD_W-1] || w_iy >= C_H || w_ix >= C_W;
  assign w_addr = ADDR_WIDTH'((32'(w_iy) * FEATURE_MAP_WIDTH + 32'(w_ix)) * INPUT_NB_CHANNELS + 32'(r_ch));
  assign w_ch_wrap = r_ch == C_CLAST;
  assign w_kx_wrap = r_kx == C_K1;
  assign w_ky_wrap = r_ky == C_K1;
  assign w_last_win = w_ch_wrap && w_kx_wrap && w_ky_wrap;
  assign w_last_x = r_x + C_STEP >= C_W;
  assign w_last_y = r_y + C_STEP >= C_H;
  assign w_final = w_last_win && w_last_x && w_last_y;
  assign w_hs = out_valid && out_ready;
  // credit counts occupancy after this cycle's pop so a steady stream keeps one element per cycle
  assign w_gen = r_state == S_RUN && ({1'b0, w_count} + {2'b0, r_pend} - {2'b0, w_hs}) < 3'd2;
  assign w_drained = !r_pend && (w_count == 2'd0 || (w_count == 2'd1 && w_hs));
  assign running = r_state != S_IDLE;
  assign mem_re = w_gen && !w_pad;
  assign mem_addr = mem_re ? w_addr : '0;
  assign {out_last_window, out_done, out_data} = w_fifo_out;
  always_comb
    w_state_nxt = r_state == S_IDLE ? (start ? S_RUN : S_IDLE) :
                  r_state == S_RUN ? (w_gen && w_final ? S_DRAIN : S_RUN) :
                  (w_drained ? S_IDLE : S_DRAIN);
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_state_nxt;
  always_ff @(posedge clk)
    if (rst) begin
      r_ch <= '0;
      r_kx <= '0;
      r_ky <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (w_gen) begin
      r_ch <= w_ch_wrap ? '0 : r_ch + 1'b1;
      if (w_ch_wrap) r_kx <= w_kx_wrap ? '0 : r_kx + 1'b1;
      if (w_ch_wrap && w_kx_wrap) r_ky <= w_ky_wrap ? '0 : r_ky + 1'b1;
      if (w_last_win) r_x <= w_last_x ? '0 : r_x + C_STEP;
      if (w_last_win && w_last_x) r_y <= w_last_y ? '0 : r_y + C_STEP;
    end
  // padding rides the same one-cycle stage as memory reads to keep stream order
  always_ff @(posedge clk)
    {r_pend, r_pend_pad, r_pend_last, r_pend_done} <= rst ? 4'b0 : {w_gen, w_pad, w_last_win, w_final};
  stream_fifo2 #(.WIDTH(DATA_WIDTH + 2)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(r_pend),
    .i_data({r_pend_last, r_pend_done, r_pend_pad ? {DATA_WIDTH{1'b0}} : mem_rdata}),
    .i_pop(out_ready),
    .o_valid(out_valid),
    .o_data(w_fifo_out),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_conv_window_streamer.sv
// tb_conv_window_streamer: three configurations checked against a loop-nest reference stream, vector table and corner sequences
module tb_conv_window_streamer;
  logic clk = 0, rst = 1, tb_start = 0, tb_ready = 0;
  int sel = 0;
  always #5 clk = ~clk;

  logic a_start, a_running, a_re, a_valid, a_last, a_done;
  logic [3:0] a_addr;
  logic [15:0] a_rdata, a_data;
  logic b_start, b_running, b_re, b_valid, b_last, b_done;
  logic [3:0] b_addr;
  logic [15:0] b_rdata, b_data;
  logic c_start, c_running, c_re, c_valid, c_last, c_done;
  logic [2:0] c_addr;
  logic [15:0] c_rdata, c_data;

  assign a_start = tb_start && sel == 0;
  assign b_start = tb_start && sel == 1;
  assign c_start = tb_start && sel == 2;

  conv_window_streamer #(.DATA_WIDTH(16), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
    .INPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .CONV_STEP(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .running(a_running), .mem_re(a_re), .mem_addr(a_addr),
    .mem_rdata(a_rdata), .out_data(a_data), .out_valid(a_valid), .out_ready(tb_ready),
    .out_last_window(a_last), .out_done(a_done));
  conv_window_streamer #(.DATA_WIDTH(16), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
    .INPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .CONV_STEP(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .running(b_running), .mem_re(b_re), .mem_addr(b_addr),
    .mem_rdata(b_rdata), .out_data(b_data), .out_valid(b_valid), .out_ready(tb_ready),
    .out_last_window(b_last), .out_done(b_done));
  conv_window_streamer #(.DATA_WIDTH(16), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .CONV_STEP(1)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .running(c_running), .mem_re(c_re), .mem_addr(c_addr),
    .mem_rdata(c_rdata), .out_data(c_data), .out_valid(c_valid), .out_ready(tb_ready),
    .out_last_window(c_last), .out_done(c_done));

  always @(posedge clk) begin
    a_rdata <= a_re ? 16'(a_addr) + 16'd1 : 16'($urandom);
    b_rdata <= b_re ? 16'(b_addr) + 16'd1 : 16'($urandom);
    c_rdata <= c_re ? 16'(c_addr) : 16'($urandom);
  end

  logic v_running, v_re, v_valid, v_last, v_done;
  logic [15:0] v_data;
  int v_addr;
  assign v_running = sel == 0 ? a_running : sel == 1 ? b_running : c_running;
  assign v_re = sel == 0 ? a_re : sel == 1 ? b_re : c_re;
  assign v_valid = sel == 0 ? a_valid : sel == 1 ? b_valid : c_valid;
  assign v_last = sel == 0 ? a_last : sel == 1 ? b_last : c_last;
  assign v_done = sel == 0 ? a_done : sel == 1 ? b_done : c_done;
  assign v_data = sel == 0 ? a_data : sel == 1 ? b_data : c_data;
  assign v_addr = sel == 0 ? int'(a_addr) : sel == 1 ? int'(b_addr) : int'(c_addr);

  typedef struct {int data; bit pad; int addr; bit last; bit done;} ref_t;
  typedef struct {int data; bit last; bit done;} got_t;
  typedef struct {int sel; int idx; int data; bit last; bit done;} vec_t;
  ref_t ref_q[$];
  got_t got_q[$];
  vec_t tbl[$];
  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void build_ref(input int w, input int h, input int c, input int k, input int s, input int off);
    ref_t e;
    ref_q.delete();
    for (int y = 0; y < h; y += s)
      for (int x = 0; x < w; x += s)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            for (int ch = 0; ch < c; ch++) begin
              int iy, ix;
              iy = y + ky - k / 2;
              ix = x + kx - k / 2;
              e.pad = iy < 0 || iy >= h || ix < 0 || ix >= w;
              e.addr = e.pad ? 0 : (iy * w + ix) * c + ch;
              e.data = e.pad ? 0 : e.addr + off;
              e.last = ky == k - 1 && kx == k - 1 && ch == c - 1;
              e.done = e.last && y + s >= h && x + s >= w;
              ref_q.push_back(e);
            end
  endfunction

  task automatic run_pass(input int mode, input int abort_after, input bit pulse_again, input string tag);
    int ri = 0, nre = 0, nonpad = 0, addr_err = 0, credit_err = 0, stab_err = 0, run_err = 0;
    int mis = 0, first_mis = -1, ndone = 0, first_valid = -1, end_cyc = -1, bad = 0, min_lat;
    bit prev_stall = 0, hs, finished = 0, prev_last = 0, prev_done = 0;
    logic [15:0] prev_data = '0;
    got_t g;
    got_q.delete();
    foreach (ref_q[i]) if (!ref_q[i].pad) nonpad++;
    min_lat = ref_q[0].pad ? 1 : 2;
    @(negedge clk);
    tb_start = 1;
    tb_ready = 0;
    @(negedge clk);
    tb_start = 0;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      tb_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      tb_start = pulse_again && (cyc == 10 || cyc == 60);
      #1;
      hs = v_valid && tb_ready;
      if (!v_running) run_err++;
      if (v_valid && first_valid < 0) first_valid = cyc;
      if (v_re) begin
        nre++;
        while (ri < ref_q.size() && ref_q[ri].pad) ri++;
        if (ri >= ref_q.size()) addr_err++;
        else begin
          if (v_addr != ref_q[ri].addr) addr_err++;
          if (ri - (got_q.size() + int'(hs)) > 1) credit_err++;
          ri++;
        end
      end
      if (prev_stall && (!v_valid || v_data != prev_data || v_last != prev_last || v_done != prev_done)) stab_err++;
      prev_stall = v_valid && !tb_ready;
      prev_data = v_data;
      prev_last = v_last;
      prev_done = v_done;
      if (hs) begin
        g.data = int'(v_data);
        g.last = v_last;
        g.done = v_done;
        got_q.push_back(g);
        if (v_done) begin
          ndone++;
          finished = 1;
          end_cyc = cyc;
        end
      end
      if (abort_after > 0 && got_q.size() == abort_after) break;
      @(negedge clk);
    end
    tb_start = 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      if (got_q[i].data != ref_q[i].data || got_q[i].last != ref_q[i].last || got_q[i].done != ref_q[i].done) begin
        mis++;
        if (first_mis < 0) first_mis = i;
      end
    check($sformatf("%s_mismatches_first_at_%0d", tag, first_mis), mis, 0);
    check({tag, "_addr_errors"}, addr_err, 0);
    check({tag, "_credit_violations"}, credit_err, 0);
    check({tag, "_hold_violations"}, stab_err, 0);
    check({tag, "_running_gaps"}, run_err, 0);
    if (abort_after > 0) begin
      check({tag, "_handshakes_before_reset"}, got_q.size(), abort_after);
      @(negedge clk);
      tb_ready = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check({tag, "_running_after_reset"}, v_running, 0);
      check({tag, "_valid_after_reset"}, v_valid, 0);
      check({tag, "_re_after_reset"}, v_re, 0);
      repeat (8) begin
        @(negedge clk);
        #1;
        if (v_running || v_valid || v_re) bad++;
      end
      check({tag, "_activity_after_reset"}, bad, 0);
    end else begin
      #1;
      check({tag, "_completed"}, finished, 1);
      check({tag, "_elements"}, got_q.size(), ref_q.size());
      check({tag, "_done_count"}, ndone, 1);
      check({tag, "_reads"}, nre, nonpad);
      check({tag, "_running_after_last"}, v_running, 0);
      check({tag, "_valid_after_last"}, v_valid, 0);
      check({tag, "_latency_ok"}, (first_valid >= 0 && first_valid + 1 >= min_lat) ? 1 : 0, 1);
      if (mode == 0) check({tag, "_throughput_ok"}, (end_cyc >= 0 && end_cyc <= ref_q.size() + 3) ? 1 : 0, 1);
    end
  endtask

  task automatic check_table(input int s);
    foreach (tbl[i])
      if (tbl[i].sel == s) begin
        if (tbl[i].idx >= got_q.size())
          check($sformatf("tbl%0d_len_for_idx%0d", s, tbl[i].idx), got_q.size(), tbl[i].idx + 1);
        else begin
          check($sformatf("tbl%0d_data_idx%0d", s, tbl[i].idx), got_q[tbl[i].idx].data, tbl[i].data);
          check($sformatf("tbl%0d_last_idx%0d", s, tbl[i].idx), got_q[tbl[i].idx].last, tbl[i].last);
          check($sformatf("tbl%0d_done_idx%0d", s, tbl[i].idx), got_q[tbl[i].idx].done, tbl[i].done);
        end
      end
  endtask

  initial begin
    int w0[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    int w22[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    for (int i = 0; i < 9; i++) tbl.push_back('{0, i, w0[i], i == 8, 1'b0});
    tbl.push_back('{0, 9, 0, 1'b0, 1'b0});
    tbl.push_back('{0, 13, 2, 1'b0, 1'b0});
    tbl.push_back('{0, 142, 0, 1'b0, 1'b0});
    tbl.push_back('{0, 143, 0, 1'b1, 1'b1});
    for (int i = 0; i < 9; i++) tbl.push_back('{1, 27 + i, w22[i], i == 8, i == 8});
    for (int i = 0; i < 8; i++) tbl.push_back('{2, i, i, i % 2 == 1, i == 7});
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_running", v_running, 0);
    check("rst_mem_re", v_re, 0);
    check("rst_mem_addr", v_addr, 0);
    check("rst_out_valid", v_valid, 0);
    check("rst_out_data", int'(v_data), 0);
    check("rst_last_window", v_last, 0);
    check("rst_done", v_done, 0);
    rst = 0;
    sel = 0;
    build_ref(4, 4, 1, 3, 1, 1);
    run_pass(0, 0, 0, "base");
    check_table(0);
    run_pass(1, 0, 0, "bp1001");
    check_table(0);
    run_pass(2, 0, 0, "rand_a");
    run_pass(2, 0, 0, "rand_b");
    sel = 1;
    build_ref(4, 4, 1, 3, 2, 1);
    run_pass(0, 0, 0, "step2");
    check_table(1);
    run_pass(2, 0, 0, "step2_rand");
    sel = 2;
    build_ref(2, 2, 2, 1, 1, 0);
    run_pass(0, 0, 0, "c2k1");
    check_table(2);
    sel = 0;
    build_ref(4, 4, 1, 3, 1, 1);
    run_pass(0, 20, 0, "abort");
    run_pass(0, 0, 0, "after_abort");
    check_table(0);
    run_pass(0, 0, 1, "restart_ignored");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
